// File: rtl/softmc_exec_arbiter_pkg.sv
// Shared constants and types for the SoftMC executor arbiter: widths,
// FSM states and the owner code that steers fetch/instruction traffic.
package softmc_exec_arbiter_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam int unsigned IMEM_ADDR_WIDTH = 10;
  localparam int unsigned INSTR_WIDTH     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_P,
    S_RUN_P,
    S_GRANT_M,
    S_RUN_M,
    S_GAP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_PROG  = 2'd1,
    OWN_MAINT = 2'd2
  } owner_t;

  function automatic owner_t state_owner(input arb_state_t s);
    case (s)
      S_RUN_P: return OWN_PROG;
      S_RUN_M: return OWN_MAINT;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/softmc_exec_arbiter_mux.sv
// Combinational steering of executor fetches to the owning source and of
// that source's returned instructions back to the executor.
module exec_src_mux
  import softmc_exec_arbiter_pkg::*;
(
  input  owner_t                     owner,
  input  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                       fetch_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] prog_fetch_addr,
  output logic                       prog_fetch_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] maint_fetch_addr,
  output logic                       maint_fetch_valid,
  input  logic [INSTR_WIDTH-1:0]     prog_instr,
  input  logic                       prog_instr_valid,
  input  logic [INSTR_WIDTH-1:0]     maint_instr,
  input  logic                       maint_instr_valid,
  output logic [INSTR_WIDTH-1:0]     exe_instr,
  output logic                       exe_instr_valid
);

  always_comb begin
    prog_fetch_addr   = fetch_addr;
    maint_fetch_addr  = fetch_addr;
    prog_fetch_valid  = LOW;
    maint_fetch_valid = LOW;
    exe_instr         = '0;
    exe_instr_valid   = LOW;
    case (owner)
      OWN_PROG: begin
        prog_fetch_valid = fetch_valid;
        exe_instr        = prog_instr;
        exe_instr_valid  = prog_instr_valid;
      end
      OWN_MAINT: begin
        maint_fetch_valid = fetch_valid;
        exe_instr         = maint_instr;
        exe_instr_valid   = maint_instr_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/softmc_exec_arbiter.sv
// Grants the single SoftMC executor to the host program or the maintenance
// controller, enforces a post-sequence gap and flags overdue maintenance.
module softmc_exec_arbiter
  import softmc_exec_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned MAINT_WAIT_MAX = 2048,
  parameter int unsigned WAIT_W         = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_calib_complete,
  input  logic                       prog_req,
  output logic                       prog_ack,
  output logic                       program_process,
  input  logic                       maint_req,
  output logic                       maint_ack,
  output logic                       exe_start,
  input  logic                       exe_fin,
  input  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                       fetch_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] prog_fetch_addr,
  output logic                       prog_fetch_valid,
  output logic [IMEM_ADDR_WIDTH-1:0] maint_fetch_addr,
  output logic                       maint_fetch_valid,
  input  logic [INSTR_WIDTH-1:0]     prog_instr,
  input  logic                       prog_instr_valid,
  input  logic [INSTR_WIDTH-1:0]     maint_instr,
  input  logic                       maint_instr_valid,
  output logic [INSTR_WIDTH-1:0]     exe_instr,
  output logic                       exe_instr_valid,
  output logic                       maint_overdue,
  output logic [15:0]                overdue_events
);

  localparam logic [3:0]        GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_HIT = WAIT_W'(MAINT_WAIT_MAX - 1);

  arb_state_t        state_q, state_d;
  owner_t            last_grant_q, last_grant_d;
  owner_t            owner;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       overdue_events_q, overdue_events_d;
  logic              prog_ack_q, prog_ack_d;
  logic              maint_ack_q, maint_ack_d;
  logic              exe_start_q, exe_start_d;
  logic              program_process_q, program_process_d;
  logic              maint_overdue_q, maint_overdue_d;
  logic              maint_wins, wait_inc;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    gap_cnt_d         = gap_cnt_q;
    prog_ack_d        = LOW;
    maint_ack_d       = LOW;
    exe_start_d       = LOW;
    program_process_d = program_process_q;
    maint_wins = maint_req && (!prog_req || maint_overdue_q || last_grant_q == OWN_PROG);
    case (state_q)
      S_IDLE: begin
        if (init_calib_complete && (prog_req || maint_req)) begin
          exe_start_d = HIGH;
          if (maint_wins) begin
            state_d      = S_GRANT_M;
            maint_ack_d  = HIGH;
            last_grant_d = OWN_MAINT;
          end else begin
            state_d      = S_GRANT_P;
            prog_ack_d   = HIGH;
            last_grant_d = OWN_PROG;
          end
        end
      end
      S_GRANT_P: begin
        state_d           = S_RUN_P;
        program_process_d = HIGH;
      end
      S_GRANT_M: state_d = S_RUN_M;
      S_RUN_P, S_RUN_M: begin
        if (exe_fin) begin
          state_d           = S_GAP;
          gap_cnt_d         = '0;
          program_process_d = LOW;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The counter passes WAIT_HIT only once between acks, so the event count
  // advances exactly once per overdue episode.
  always_comb begin
    wait_inc         = maint_req && state_q != S_GRANT_M && state_q != S_RUN_M;
    wait_cnt_d       = wait_cnt_q;
    maint_overdue_d  = maint_overdue_q;
    overdue_events_d = overdue_events_q;
    if (maint_ack_q) begin
      wait_cnt_d      = '0;
      maint_overdue_d = LOW;
    end else if (wait_inc && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_q == WAIT_HIT) begin
        maint_overdue_d = HIGH;
        if (overdue_events_q != 16'hFFFF) overdue_events_d = overdue_events_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      last_grant_q      <= OWN_PROG;
      gap_cnt_q         <= '0;
      wait_cnt_q        <= '0;
      overdue_events_q  <= '0;
      prog_ack_q        <= LOW;
      maint_ack_q       <= LOW;
      exe_start_q       <= LOW;
      program_process_q <= LOW;
      maint_overdue_q   <= LOW;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      gap_cnt_q         <= gap_cnt_d;
      wait_cnt_q        <= wait_cnt_d;
      overdue_events_q  <= overdue_events_d;
      prog_ack_q        <= prog_ack_d;
      maint_ack_q       <= maint_ack_d;
      exe_start_q       <= exe_start_d;
      program_process_q <= program_process_d;
      maint_overdue_q   <= maint_overdue_d;
    end
  end

  always_comb owner = state_owner(state_q);

  assign prog_ack        = prog_ack_q;
  assign maint_ack       = maint_ack_q;
  assign exe_start       = exe_start_q;
  assign program_process = program_process_q;
  assign maint_overdue   = maint_overdue_q;
  assign overdue_events  = overdue_events_q;

  exec_src_mux u_mux (
    .owner            (owner),
    .fetch_addr       (fetch_addr),
    .fetch_valid      (fetch_valid),
    .prog_fetch_addr  (prog_fetch_addr),
    .prog_fetch_valid (prog_fetch_valid),
    .maint_fetch_addr (maint_fetch_addr),
    .maint_fetch_valid(maint_fetch_valid),
    .prog_instr       (prog_instr),
    .prog_instr_valid (prog_instr_valid),
    .maint_instr      (maint_instr),
    .maint_instr_valid(maint_instr_valid),
    .exe_instr        (exe_instr),
    .exe_instr_valid  (exe_instr_valid)
  );

endmodule

// File: tb/tb_softmc_exec_arbiter.sv
// Self-checking bench for softmc_exec_arbiter: directed scenarios plus a
// randomized arbitration run checked against a transaction-level model.
module tb_softmc_exec_arbiter;
  import softmc_exec_arbiter_pkg::*;

  localparam int unsigned GAP = 2;
  localparam int unsigned MAX = 2048;

  logic clk = 1'b0;
  logic rst, init_calib_complete, prog_req, maint_req, exe_fin, fetch_valid;
  logic prog_ack, maint_ack, exe_start, program_process, maint_overdue;
  logic prog_fetch_valid, maint_fetch_valid, exe_instr_valid;
  logic prog_instr_valid, maint_instr_valid;
  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr, prog_fetch_addr, maint_fetch_addr;
  logic [INSTR_WIDTH-1:0]     prog_instr, maint_instr, exe_instr;
  logic [15:0]                overdue_events;

  int unsigned n_cmp = 0, n_err = 0, cyc = 0;
  int unsigned idle_at = 0;     // first cycle in which the arbiter is idle again
  int unsigned model_last = 0;  // 0 = program granted last, 1 = maintenance

  always #5 clk = ~clk;

  softmc_exec_arbiter #(.GAP_CYCLES(GAP), .MAINT_WAIT_MAX(MAX), .WAIT_W(12)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .prog_req(prog_req), .prog_ack(prog_ack), .program_process(program_process),
    .maint_req(maint_req), .maint_ack(maint_ack), .exe_start(exe_start), .exe_fin(exe_fin),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .prog_fetch_addr(prog_fetch_addr), .prog_fetch_valid(prog_fetch_valid),
    .maint_fetch_addr(maint_fetch_addr), .maint_fetch_valid(maint_fetch_valid),
    .prog_instr(prog_instr), .prog_instr_valid(prog_instr_valid),
    .maint_instr(maint_instr), .maint_instr_valid(maint_instr_valid),
    .exe_instr(exe_instr), .exe_instr_valid(exe_instr_valid),
    .maint_overdue(maint_overdue), .overdue_events(overdue_events)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic finish_run();
    exe_fin = 1'b1;
    tick();
    exe_fin = 1'b0;
    idle_at = cyc + GAP;
  endtask

  task automatic wait_idle();
    while (cyc < idle_at) tick();
  endtask

  // Winner from the arbitration rules: lone requester, overdue maintenance,
  // otherwise the source not granted last.
  function automatic int unsigned pick(input bit p, input bit m, input bit od, input int unsigned last);
    if (p && !m) return 0;
    if (m && !p) return 1;
    if (od) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; init_calib_complete = 1'b1; prog_req = 1'b0; maint_req = 1'b0; exe_fin = 1'b0;
    fetch_addr = '0; fetch_valid = 1'b0; prog_instr = '0; prog_instr_valid = 1'b0;
    maint_instr = '0; maint_instr_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start, program_process, maint_overdue} !== 5'b0 || overdue_events !== 16'd0) begin
      n_err++; $display("FAIL reset_regs: got %b/%h exp 00000/0000",
        {prog_ack, maint_ack, exe_start, program_process, maint_overdue}, overdue_events);
    end
    fetch_valid = 1'b1; maint_instr_valid = 1'b1; maint_instr = 32'hFFFF_FFFF; #1;
    n_cmp++;
    if ({prog_fetch_valid, maint_fetch_valid, exe_instr_valid} !== 3'b0 || exe_instr !== '0) begin
      n_err++; $display("FAIL reset_route: got %b instr %h exp 000 instr 0",
        {prog_fetch_valid, maint_fetch_valid, exe_instr_valid}, exe_instr);
    end
    fetch_valid = 1'b0; maint_instr_valid = 1'b0; maint_instr = '0;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start} !== 3'b0) begin
      n_err++; $display("FAIL reset_no_ack: got %b exp 000", {prog_ack, maint_ack, exe_start});
    end
    idle_at = cyc; model_last = 0;
  endtask

  task automatic test_prog_basic();
    logic exp_ack;
    wait_idle();
    prog_req = 1'b1;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start, program_process} !== 4'b1010) begin
      n_err++; $display("FAIL basic_grant: got %b exp 1010", {prog_ack, maint_ack, exe_start, program_process});
    end
    prog_req = 1'b0;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start, program_process} !== 4'b0001) begin
      n_err++; $display("FAIL basic_run: got %b exp 0001", {prog_ack, maint_ack, exe_start, program_process});
    end
    repeat (27) tick();
    n_cmp++;
    if ({prog_ack, exe_start, program_process} !== 3'b001) begin
      n_err++; $display("FAIL basic_hold: got %b exp 001", {prog_ack, exe_start, program_process});
    end
    finish_run();
    n_cmp++;
    if (program_process !== 1'b0) begin
      n_err++; $display("FAIL basic_fin: program_process got %b exp 0", program_process);
    end
    prog_req = 1'b1;
    for (int unsigned k = 1; k <= GAP + 1; k++) begin
      tick();
      exp_ack = (k == GAP + 1);
      n_cmp++;
      if (prog_ack !== exp_ack || exe_start !== exp_ack) begin
        n_err++; $display("FAIL basic_gap k=%0d: ack/start got %b%b exp %b%b", k, prog_ack, exe_start, exp_ack, exp_ack);
      end
    end
    prog_req = 1'b0;
    tick();
    finish_run();
    model_last = 0;
  endtask

  task automatic test_fetch_maint();
    wait_idle();
    maint_req = 1'b1;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start} !== 3'b011) begin
      n_err++; $display("FAIL fetch_grant: got %b exp 011", {prog_ack, maint_ack, exe_start});
    end
    maint_req = 1'b0;
    tick();
    fetch_addr = IMEM_ADDR_WIDTH'(5); fetch_valid = 1'b1;
    maint_instr = 32'h0000_00A5; maint_instr_valid = 1'b1;
    prog_instr = 32'h0000_005A; prog_instr_valid = 1'b1;
    #1;
    n_cmp++;
    if ({prog_fetch_valid, maint_fetch_valid} !== 2'b01 || prog_fetch_addr !== IMEM_ADDR_WIDTH'(5)
        || maint_fetch_addr !== IMEM_ADDR_WIDTH'(5)) begin
      n_err++; $display("FAIL fetch_route: valids %b addrs %0d/%0d exp 01 5/5",
        {prog_fetch_valid, maint_fetch_valid}, prog_fetch_addr, maint_fetch_addr);
    end
    n_cmp++;
    if (exe_instr !== 32'h0000_00A5 || exe_instr_valid !== 1'b1) begin
      n_err++; $display("FAIL fetch_instr: got %h/%b exp 000000a5/1", exe_instr, exe_instr_valid);
    end
    finish_run();
    #1;
    n_cmp++;
    if ({prog_fetch_valid, maint_fetch_valid, exe_instr_valid} !== 3'b0 || exe_instr !== '0) begin
      n_err++; $display("FAIL fetch_gap: got %b instr %h exp 000 instr 0",
        {prog_fetch_valid, maint_fetch_valid, exe_instr_valid}, exe_instr);
    end
    fetch_valid = 1'b0; maint_instr_valid = 1'b0; prog_instr_valid = 1'b0;
    model_last = 1;
  endtask

  task automatic test_tie_after_reset();
    logic exp_ack;
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_at = cyc; model_last = 0;
    prog_req = 1'b1; maint_req = 1'b1;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start} !== 3'b011) begin
      n_err++; $display("FAIL tie_first: got %b exp 011", {prog_ack, maint_ack, exe_start});
    end
    maint_req = 1'b0;
    repeat (3) tick();
    finish_run();
    for (int unsigned k = 1; k <= GAP + 1; k++) begin
      tick();
      exp_ack = (k == GAP + 1);
      n_cmp++;
      if (prog_ack !== exp_ack || maint_ack !== 1'b0) begin
        n_err++; $display("FAIL tie_second k=%0d: got p%b m%b exp p%b m0", k, prog_ack, maint_ack, exp_ack);
      end
    end
    prog_req = 1'b0;
    tick();
    finish_run();
    model_last = 0;
  endtask

  task automatic test_overdue();
    logic exp_ack;
    wait_idle();
    maint_req = 1'b1;
    tick();
    maint_req = 1'b0;
    tick();
    finish_run();
    wait_idle();
    prog_req = 1'b1;
    tick();
    n_cmp++;
    if (prog_ack !== 1'b1) begin
      n_err++; $display("FAIL od_prog_grant: got %b exp 1", prog_ack);
    end
    prog_req = 1'b0;
    tick();
    maint_req = 1'b1;
    repeat (MAX - 1) tick();
    n_cmp++;
    if (maint_overdue !== 1'b0 || overdue_events !== 16'd0) begin
      n_err++; $display("FAIL od_early: got %b/%0d exp 0/0", maint_overdue, overdue_events);
    end
    tick();
    n_cmp++;
    if (maint_overdue !== 1'b1 || overdue_events !== 16'd1) begin
      n_err++; $display("FAIL od_set: got %b/%0d exp 1/1", maint_overdue, overdue_events);
    end
    prog_req = 1'b1;
    finish_run();
    for (int unsigned k = 1; k <= GAP + 1; k++) begin
      tick();
      exp_ack = (k == GAP + 1);
      n_cmp++;
      if (maint_ack !== exp_ack || prog_ack !== 1'b0) begin
        n_err++; $display("FAIL od_priority k=%0d: got m%b p%b exp m%b p0", k, maint_ack, prog_ack, exp_ack);
      end
    end
    maint_req = 1'b0; prog_req = 1'b0;
    tick();
    n_cmp++;
    if (maint_overdue !== 1'b0 || overdue_events !== 16'd1) begin
      n_err++; $display("FAIL od_clear: got %b/%0d exp 0/1", maint_overdue, overdue_events);
    end
    finish_run();
    model_last = 1;
  endtask

  task automatic test_calib_gate();
    int unsigned seen;
    int unsigned win;
    wait_idle();
    init_calib_complete = 1'b0; prog_req = 1'b1; maint_req = 1'b1;
    seen = 0;
    repeat (100) begin
      tick();
      if (prog_ack || maint_ack || exe_start) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL calib_block: pulses got %0d exp 0", seen);
    end
    init_calib_complete = 1'b1;
    win = pick(1'b1, 1'b1, 1'b0, model_last);
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack} !== {win == 0, win == 1}) begin
      n_err++; $display("FAIL calib_release: got %b exp %b", {prog_ack, maint_ack}, {win == 0, win == 1});
    end
    prog_req = 1'b0; maint_req = 1'b0;
    tick();
    init_calib_complete = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (program_process !== (win == 0)) begin
      n_err++; $display("FAIL calib_run_kept: got %b exp %b", program_process, win == 0);
    end
    finish_run();
    n_cmp++;
    if (program_process !== 1'b0) begin
      n_err++; $display("FAIL calib_fin: got %b exp 0", program_process);
    end
    init_calib_complete = 1'b1;
    model_last = win;
  endtask

  task automatic test_random_arbitration();
    bit [1:0] pat;
    bit pre, hit;
    int unsigned r_cyc, exp_ack, win, len;
    logic [INSTR_WIDTH-1:0] exp_i;
    logic exp_v;
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_at = cyc; model_last = 0;
    pre = 1'b0; pat = 2'b00; r_cyc = cyc;
    for (int it = 0; it < 24; it++) begin
      if (!pre) begin
        repeat ($urandom_range(0, 3)) tick();
        pat = 2'($urandom_range(1, 3));
        prog_req = pat[0]; maint_req = pat[1]; r_cyc = cyc;
      end
      win = pick(pat[0], pat[1], 1'b0, model_last);
      exp_ack = ((r_cyc > idle_at) ? r_cyc : idle_at) + 1;
      hit = 1'b0;
      for (int k = 0; k < 16 && !hit; k++) begin
        tick();
        n_cmp++;
        if (cyc == exp_ack) begin
          hit = 1'b1;
          if ({prog_ack, maint_ack, exe_start} !== {win == 0, win == 1, 1'b1}) begin
            n_err++; $display("FAIL rnd_grant it=%0d pat=%b: got %b exp %b", it, pat,
              {prog_ack, maint_ack, exe_start}, {win == 0, win == 1, 1'b1});
          end
        end else if ({prog_ack, maint_ack, exe_start} !== 3'b0) begin
          n_err++; $display("FAIL rnd_early it=%0d cyc=%0d: got %b exp 000", it, cyc, {prog_ack, maint_ack, exe_start});
        end
      end
      if (!hit) begin
        n_cmp++; n_err++; $display("FAIL rnd_timeout it=%0d: no grant cycle reached exp %0d", it, exp_ack);
      end
      prog_req = 1'b0; maint_req = 1'b0;
      exe_fin = ($urandom_range(0, 3) == 0);
      tick();
      exe_fin = 1'b0;
      n_cmp++;
      if (program_process !== (win == 0)) begin
        n_err++; $display("FAIL rnd_process it=%0d: got %b exp %b", it, program_process, win == 0);
      end
      len = $urandom_range(1, 6);
      for (int unsigned k = 0; k < len; k++) begin
        fetch_addr = IMEM_ADDR_WIDTH'($urandom); fetch_valid = 1'($urandom);
        prog_instr = $urandom; prog_instr_valid = 1'($urandom);
        maint_instr = $urandom; maint_instr_valid = 1'($urandom);
        #1;
        exp_i = (win == 1) ? maint_instr : prog_instr;
        exp_v = (win == 1) ? maint_instr_valid : prog_instr_valid;
        n_cmp++;
        if ({prog_fetch_valid, maint_fetch_valid} !== {fetch_valid && win == 0, fetch_valid && win == 1}
            || prog_fetch_addr !== fetch_addr || maint_fetch_addr !== fetch_addr
            || exe_instr !== exp_i || exe_instr_valid !== exp_v) begin
          n_err++; $display("FAIL rnd_route it=%0d: fv %b instr %h/%b exp fv %b instr %h/%b", it,
            {prog_fetch_valid, maint_fetch_valid}, exe_instr, exe_instr_valid,
            {fetch_valid && win == 0, fetch_valid && win == 1}, exp_i, exp_v);
        end
        if (k + 1 < len) tick();
      end
      pre = 1'($urandom_range(0, 1));
      if (pre) begin
        pat = 2'($urandom_range(1, 3));
        prog_req = pat[0]; maint_req = pat[1]; r_cyc = cyc;
      end
      finish_run();
      fetch_valid = 1'b1; prog_instr_valid = 1'b1; maint_instr_valid = 1'b1;
      #1;
      n_cmp++;
      if ({program_process, prog_fetch_valid, maint_fetch_valid, exe_instr_valid} !== 4'b0) begin
        n_err++; $display("FAIL rnd_gap it=%0d: got %b exp 0000", it,
          {program_process, prog_fetch_valid, maint_fetch_valid, exe_instr_valid});
      end
      fetch_valid = 1'b0; prog_instr_valid = 1'b0; maint_instr_valid = 1'b0;
      model_last = win;
    end
    prog_req = 1'b0; maint_req = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int unsigned seen;
    int unsigned win;
    wait_idle();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1; fetch_addr = '0; fetch_valid = 1'b1; prog_instr = 32'h1234_5678; prog_instr_valid = 1'b1;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start, program_process, maint_overdue, prog_fetch_valid,
         maint_fetch_valid, exe_instr_valid} !== 8'b0 || overdue_events !== 16'd0 || exe_instr !== '0
        || prog_fetch_addr !== '0 || maint_fetch_addr !== '0) begin
      n_err++; $display("FAIL rst_mid: got %b ev %0d instr %h exp all zero",
        {prog_ack, maint_ack, exe_start, program_process, maint_overdue, prog_fetch_valid,
         maint_fetch_valid, exe_instr_valid}, overdue_events, exe_instr);
    end
    rst = 1'b0; fetch_valid = 1'b0; prog_instr_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      tick();
      if (prog_ack || maint_ack || exe_start || program_process) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL rst_quiet: pulses got %0d exp 0", seen);
    end
    win = pick(1'b1, 1'b1, 1'b0, 0);
    prog_req = 1'b1; maint_req = 1'b1;
    tick();
    n_cmp++;
    if ({prog_ack, maint_ack, exe_start} !== {win == 0, win == 1, 1'b1}) begin
      n_err++; $display("FAIL rst_rearb: got %b exp %b", {prog_ack, maint_ack, exe_start}, {win == 0, win == 1, 1'b1});
    end
    prog_req = 1'b0; maint_req = 1'b0;
    tick();
    finish_run();
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_prog_basic();
    test_fetch_maint();
    test_tie_after_reset();
    test_overdue();
    test_calib_gate();
    test_random_arbitration();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
